lut_neuron_arbiter: RTL and testbench

Shares one LUT-neuron evaluation port (IN_BITS-wide index in, OUT_BITS-wide activation out, purely combinational) between NUM_REQ requesters using round-robin arbitration. The block registers the granted index onto the LUT address, captures the LUT result, and returns it on a single shared response channel tagged with the requester ID. It sits between time-multiplexed layer logic and a physical neuron LUT so that one ROM serves several logical evaluation streams.

---
 rtl/lut_neuron_arbiter.sv | 103 ++++++++++
 tb/tb_lut_neuron_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_arbiter.sv
// Round-robin arbiter sharing one combinational neuron LUT among several requesters,
// with a two-stage pipeline (address register, result register) and a tagged response.
module lut_neuron_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 2,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*IN_BITS-1:0]   req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [IN_BITS-1:0]           lut_addr,
  input  logic [OUT_BITS-1:0]          lut_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [OUT_BITS-1:0]          rsp_data,
  output logic [ID_W-1:0]              rsp_id
);

  logic               a_valid;
  logic [ID_W-1:0]    a_id;
  logic [ID_W-1:0]    ptr;
  logic               b_free;
  logic               a_free;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W:0]      idx_sum;
  logic [ID_W-1:0]    idx_w;
  logic [IN_BITS-1:0] addr_arr [NUM_REQ];
  logic               accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*IN_BITS +: IN_BITS];
  end

  assign b_free = !rsp_valid || rsp_ready;
  assign a_free = !a_valid || b_free;

  // Search starts at the pointer and wraps modulo NUM_REQ; idx_sum has one spare bit
  // so the wrap subtraction never overflows.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    idx_w       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
        idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
      end
      idx_w = idx_sum[ID_W-1:0];
      if (!grant_found && req_valid[idx_w]) begin
        grant_found = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (a_free && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept   = a_free && grant_found;
  assign next_ptr = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      a_id     <= '0;
      lut_addr <= '0;
      ptr      <= '0;
    end else if (accept) begin
      a_valid  <= 1'b1;
      a_id     <= grant_idx;
      lut_addr <= addr_arr[grant_idx];
      ptr      <= next_ptr;
    end else if (b_free) begin
      a_valid  <= 1'b0;
    end
  end

  // Stage B holds its contents whenever the consumer stalls a valid response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (b_free) begin
      rsp_valid <= a_valid;
      if (a_valid) begin
        rsp_data <= lut_data;
        rsp_id   <= a_id;
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_arbiter.sv
// Self-checking bench for lut_neuron_arbiter: a toy LUT model drives lut_data and a
// scoreboard queue holds expected {id, data} responses in grant order.
module tb_lut_neuron_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int IN_BITS  = 4;
  localparam int OUT_BITS = 2;
  localparam int ID_W     = 2;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ*IN_BITS-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [IN_BITS-1:0]         lut_addr;
  logic [OUT_BITS-1:0]        lut_data;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b1;
  logic [OUT_BITS-1:0]        rsp_data;
  logic [ID_W-1:0]            rsp_id;

  int checks = 0;
  int errors = 0;
  logic [ID_W+OUT_BITS-1:0] sb [$];

  always #5 clk = ~clk;

  assign lut_data = (lut_addr == 4'b1111) ? 2'b01 : 2'b00;

  lut_neuron_arbiter #(
    .NUM_REQ(NUM_REQ), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [OUT_BITS-1:0] lut_model(input logic [IN_BITS-1:0] a);
    return (a == 4'b1111) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [ID_W+OUT_BITS-1:0] expect_rsp(input int id);
    logic [IN_BITS-1:0] a;
    a = req_addr[id*IN_BITS +: IN_BITS];
    return {ID_W'(id), lut_model(a)};
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, lut_addr, rsp_data, rsp_id} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b ready=%b addr=%h data=%h id=%0d, required all zero",
               rsp_valid, req_ready, lut_addr, rsp_data, rsp_id);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_addr  = 16'h000F;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL single_grant: got %b, required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_latency: got rsp_valid=%b one cycle early, required 0", rsp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 2'b01, 2'd0}) begin
      errors++;
      $display("[TB] FAIL single_rsp: got valid=%b data=%b id=%0d, required 1/01/0", rsp_valid, rsp_data, rsp_id);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_once: got rsp_valid=%b, required 0", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    logic [ID_W+OUT_BITS-1:0] e;
    do_reset();
    req_addr  = {4'd3, 4'd2, 4'd1, 4'd0};
    req_valid = 4'b1111;
    for (int c = 0; c < 6 + 6; c++) begin
      if (c == 6) req_valid = '0;
      @(negedge clk);
      if (c < 6) begin
        checks++;
        if (req_ready !== (4'(1) << exp_g[c])) begin
          errors++; $display("[TB] FAIL rr_grant[%0d]: got %b, required %b", c, req_ready, 4'(1) << exp_g[c]);
        end
        sb.push_back(expect_rsp(exp_g[c]));
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL rr_extra_rsp: got id=%0d data=%b, required none", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            errors++; $display("[TB] FAIL rr_rsp: got id=%0d data=%b, required id=%0d data=%b", rsp_id, rsp_data, e[3:2], e[1:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL rr_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    logic [NUM_REQ-1:0] vld [3] = '{4'b0100, 4'b0110, 4'b0110};
    int                 exp_g [3] = '{2, 1, 2};
    logic [ID_W+OUT_BITS-1:0] e;
    do_reset();
    req_addr = {4'd0, 4'hF, 4'd7, 4'd0};
    for (int c = 0; c < 3 + 5; c++) begin
      req_valid = (c < 3) ? vld[c] : '0;
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (req_ready !== (4'(1) << exp_g[c])) begin
          errors++; $display("[TB] FAIL wrap_grant[%0d]: got %b, required %b", c, req_ready, 4'(1) << exp_g[c]);
        end
        sb.push_back(expect_rsp(exp_g[c]));
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL wrap_extra_rsp: got id=%0d, required none", rsp_id);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            errors++; $display("[TB] FAIL wrap_rsp: got id=%0d data=%b, required id=%0d data=%b", rsp_id, rsp_data, e[3:2], e[1:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL wrap_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic rdy [10]   = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    int   exp_g [10] = '{0, 1, 2, -1, -1, -1, 3, 0, 1, 2};
    logic [ID_W+OUT_BITS:0] held;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [ID_W+OUT_BITS-1:0] e;
    do_reset();
    req_addr  = {4'hF, 4'h5, 4'hF, 4'h2};
    req_valid = 4'b1111;
    held = '0;
    for (int c = 0; c < 10 + 6; c++) begin
      if (c == 10) req_valid = '0;
      rsp_ready = (c < 10) ? rdy[c] : 1'b1;
      @(negedge clk);
      if (c < 10) begin
        exp_rdy = (exp_g[c] < 0) ? 4'b0000 : (4'(1) << exp_g[c]);
        checks++;
        if (req_ready !== exp_rdy) begin
          errors++; $display("[TB] FAIL bp_grant[%0d]: got %b, required %b", c, req_ready, exp_rdy);
        end
        if (exp_g[c] >= 0) sb.push_back(expect_rsp(exp_g[c]));
      end
      if (c == 3) held = {rsp_valid, rsp_id, rsp_data};
      if (c == 4 || c == 5) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== held || held[ID_W+OUT_BITS] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d data=%b, required v=1 id=%0d data=%b",
                   c, rsp_valid, rsp_id, rsp_data, held[3:2], held[1:0]);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL bp_extra_rsp: got id=%0d, required none", rsp_id);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            errors++; $display("[TB] FAIL bp_rsp: got id=%0d data=%b, required id=%0d data=%b", rsp_id, rsp_data, e[3:2], e[1:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL bp_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    req_addr  = {4'd0, 4'd0, 4'hF, 4'd0};
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("[TB] FAIL mid_grant: got %b, required 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || lut_addr !== 4'd0) begin
      errors++; $display("[TB] FAIL mid_reset: got valid=%b addr=%h, required 0/0", rsp_valid, lut_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL mid_late_rsp[%0d]: got rsp_valid=%b, required 0", c, rsp_valid);
      end
      @(posedge clk); #1;
    end
    req_addr  = {4'd0, 4'd0, 4'd3, 4'd0};
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("[TB] FAIL mid_first_grant: got %b, required 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 2'b00}) begin
      errors++; $display("[TB] FAIL mid_post_rsp: got v=%b id=%0d data=%b, required 1/1/00", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
        errors++; $display("[TB] FAIL idle[%0d]: got valid=%b ready=%b, required 0/0000", c, rsp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("[TB] FAIL idle_ptr_kept: got %b, required 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_midflight();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
